// File: rtl/muldiv_wb_queue_pkg.sv
// muldiv_wbq_pkg: shared defaults and entry type for the MulDiv writeback queue
package muldiv_wbq_pkg;
  localparam int XLEN_D = 32;
  localparam int TAG_W_D = 5;
  localparam int DEPTH_D = 2;
  localparam int STARVE_MAX_D = 8;
  typedef struct packed {
    logic [TAG_W_D-1:0] tag;
    logic [XLEN_D-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/muldiv_wb_queue_if.sv
// muldiv_wb_queue_if: MulDiv response, pipeline arbitration and regfile write signals
interface muldiv_wb_queue_if
  import muldiv_wbq_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int TAG_W = TAG_W_D,
  parameter int DEPTH = DEPTH_D
);
  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic pipe_wen;
  logic wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0] wb_data;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic pipe_stall;
  modport master (
    output in_valid, in_data, in_tag, pipe_wen,
    input in_ready, wb_valid, wb_tag, wb_data, level, pipe_stall
  );
  modport slave (
    input in_valid, in_data, in_tag, pipe_wen,
    output in_ready, wb_valid, wb_tag, wb_data, level, pipe_stall
  );
endinterface

// File: rtl/muldiv_wb_queue_fifo.sv
// wbq_fifo: generic circular buffer with explicitly wrapped pointers and occupancy count
module wbq_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // pointer and count update; reset discards everything buffered
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // storage write at the tail
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= din;
  end
  assign dout = mem[head];
endmodule

// File: rtl/muldiv_wb_queue.sv
// muldiv_wb_queue: buffers MulDiv responses and drains them into the regfile port behind pipeline writeback; optional starve stall via MULDIV_WBQ_STARVE_EN
module muldiv_wb_queue
  import muldiv_wbq_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int TAG_W = TAG_W_D,
  parameter int DEPTH = DEPTH_D
`ifdef MULDIV_WBQ_STARVE_EN
  , parameter int STARVE_MAX = STARVE_MAX_D
`endif
) (
  input logic clock,
  input logic reset,
  muldiv_wb_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic [TAG_W+XLEN-1:0] head;
  logic push, pop;
  wbq_fifo #(.W(TAG_W + XLEN), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({bus.in_tag, bus.in_data}),
    .dout(head),
    .count(count)
  );
  // ready from registered occupancy only; x0 writes handshake but are dropped; pipeline wins the port
  always_comb begin
    bus.in_ready = count != CW'(DEPTH);
    push = bus.in_valid && bus.in_ready && bus.in_tag != '0;
    pop = count != '0 && !bus.pipe_wen;
    bus.wb_valid = pop;
    bus.wb_tag = head[XLEN +: TAG_W];
    bus.wb_data = head[XLEN-1:0];
    bus.level = count;
  end
`ifdef MULDIV_WBQ_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  // count cycles a valid head loses the port, saturating; any pop or empty queue clears it
  always_ff @(posedge clock) begin
    if (reset || pop || count == '0) starve <= '0;
    else if (bus.pipe_wen && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
  end
  assign bus.pipe_stall = starve == SW'(STARVE_MAX);
`else
  assign bus.pipe_stall = 1'b0;
`endif
endmodule
